mem_wb_skid: RTL and testbench

- Parametrised MEM/WB pipeline boundary that replaces the plain MEM/WB register.
- Adds a valid/ready handshake on both sides, backed by a 2-entry skid buffer, so writeback back-pressure can stall MEM without a combinational ready path.
- Also provides: synchronous flush, load-data extraction (byte/half/word with sign or zero extension), register-0 write suppression, and a saturating stall counter.
- Sits between the MEM stage and the register-file write port.

---
 rtl/mem_wb_skid.sv | 163 ++++++++++++++++
 tb/tb_mem_wb_skid.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM/WB boundary: 2-entry skid buffer with load extraction, x0 write guard, stall counter.
// Latency: an entry accepted at edge N appears on wb_* after edge N; 1 entry/cycle when streaming.
// Backpressure: mem_ready_o is registered (low only when both entries are occupied), never combinational on wb_ready_i.
module mem_wb_skid #(
   parameter int DATA_W         = 32,
   parameter int REG_ADDR_W     = 5,
   parameter bit ZERO_REG_GUARD = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic                  mem_write_reg_en_i,
   input  logic [REG_ADDR_W-1:0] mem_write_reg_addr_i,
   input  logic [DATA_W-1:0]     mem_write_reg_data_i,
   input  logic                  mem_load_i,
   input  logic [1:0]            mem_load_size_i,
   input  logic                  mem_load_signed_i,
   input  logic [1:0]            mem_byte_off_i,
   input  logic [31:0]           mem_load_data_i,
   input  logic                  wb_ready_i,
   output logic                  wb_valid_o,
   output logic                  wb_write_reg_en_o,
   output logic [REG_ADDR_W-1:0] wb_write_reg_addr_o,
   output logic [DATA_W-1:0]     wb_write_reg_data_o,
   output logic [CNT_W-1:0]      wb_stall_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic                  en;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } entry_t;

   state_t           state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   entry_t           in_ent;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [DATA_W-1:0] ext;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic             accept;
   logic             emit;

   assign mem_ready_o = (state_q != FULL);
   assign wb_valid_o  = (state_q != EMPTY);
   assign accept      = mem_valid_i & mem_ready_o;
   assign emit        = wb_valid_o & wb_ready_i;

   // Main entry is kept zeroed whenever it is not holding data, so EMPTY drives all-zero outputs.
   assign wb_write_reg_en_o   = main_q.en;
   assign wb_write_reg_addr_o = main_q.addr;
   assign wb_write_reg_data_o = main_q.data;
   assign wb_stall_cnt_o      = stall_cnt_q;

   assign byte_lane = mem_load_data_i[{mem_byte_off_i, 3'b000} +: 8];
   assign half_lane = mem_byte_off_i[1] ? mem_load_data_i[31:16] : mem_load_data_i[15:0];

   // Load-data extraction: fill the whole word with the extension bit, then overlay the lane.
   always_comb begin
      ext = '0;
      case (mem_load_size_i)
         2'b00: begin
            ext      = {DATA_W{mem_load_signed_i & byte_lane[7]}};
            ext[7:0] = byte_lane;
         end
         2'b01: begin
            ext       = {DATA_W{mem_load_signed_i & half_lane[15]}};
            ext[15:0] = half_lane;
         end
         default: begin
            ext       = {DATA_W{mem_load_signed_i & mem_load_data_i[31]}};
            ext[31:0] = mem_load_data_i;
         end
      endcase
   end

   // Build the entry to capture; writes to register 0 keep addr/data but lose their enable.
   always_comb begin
      in_ent      = '0;
      in_ent.addr = mem_write_reg_addr_i;
      in_ent.data = mem_load_i ? ext : mem_write_reg_data_i;
      in_ent.en   = mem_write_reg_en_i &
                    ~(ZERO_REG_GUARD && (mem_write_reg_addr_i == '0));
   end

   // Skid-buffer next state; flush dominates any handshake in the same cycle.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_ent;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_d = in_ent;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_ent;
               end else if (emit) begin
                  state_d = EMPTY;
                  main_d  = '0;
               end
            end
            FULL: begin
               if (emit) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   // Saturating count of cycles where writeback holds off a valid entry.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (wb_valid_o && !wb_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State and storage registers; reset clears everything including the stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: directed scenarios plus random traffic against a queue-based model.
// Latency: model is advanced per clock and compared 1 time unit after each rising edge.
// Backpressure: model capacity is two entries; ready is expected whenever fewer than two are held.
module tb_mem_wb_skid;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          mem_valid_i;
   logic          mem_ready_o;
   logic          mem_write_reg_en_i;
   logic [AW-1:0] mem_write_reg_addr_i;
   logic [DW-1:0] mem_write_reg_data_i;
   logic          mem_load_i;
   logic [1:0]    mem_load_size_i;
   logic          mem_load_signed_i;
   logic [1:0]    mem_byte_off_i;
   logic [31:0]   mem_load_data_i;
   logic          wb_ready_i;
   logic          wb_valid_o;
   logic          wb_write_reg_en_o;
   logic [AW-1:0] wb_write_reg_addr_o;
   logic [DW-1:0] wb_write_reg_data_o;
   logic [CW-1:0] wb_stall_cnt_o;

   always #5 clk = ~clk;

   mem_wb_skid #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG_GUARD(1'b1), .CNT_W(CW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush_i              (flush_i),
      .mem_valid_i          (mem_valid_i),
      .mem_ready_o          (mem_ready_o),
      .mem_write_reg_en_i   (mem_write_reg_en_i),
      .mem_write_reg_addr_i (mem_write_reg_addr_i),
      .mem_write_reg_data_i (mem_write_reg_data_i),
      .mem_load_i           (mem_load_i),
      .mem_load_size_i      (mem_load_size_i),
      .mem_load_signed_i    (mem_load_signed_i),
      .mem_byte_off_i       (mem_byte_off_i),
      .mem_load_data_i      (mem_load_data_i),
      .wb_ready_i           (wb_ready_i),
      .wb_valid_o           (wb_valid_o),
      .wb_write_reg_en_o    (wb_write_reg_en_o),
      .wb_write_reg_addr_o  (wb_write_reg_addr_o),
      .wb_write_reg_data_o  (wb_write_reg_data_o),
      .wb_stall_cnt_o       (wb_stall_cnt_o)
   );

   typedef struct {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_cnt;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Arithmetic load extraction: shift the lane down, mask it, then sign-extend by subtraction.
   function automatic logic [31:0] ref_ext(input logic [1:0] size, input logic sx,
                                           input logic [1:0] off, input logic [31:0] d);
      longint v;
      int     bits;
      int     sh;
      case (size)
         2'b00:   begin bits = 8;  sh = 8 * int'(off); end
         2'b01:   begin bits = 16; sh = off[1] ? 16 : 0; end
         default: begin bits = 32; sh = 0; end
      endcase
      v = longint'(d >> sh) & ((longint'(1) << bits) - 1);
      if (sx && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return v[31:0];
   endfunction

   function automatic ent_t ref_entry();
      ent_t e;
      e.addr = mem_write_reg_addr_i;
      e.en   = mem_write_reg_en_i && (mem_write_reg_addr_i != 0);
      e.data = mem_load_i ? ref_ext(mem_load_size_i, mem_load_signed_i, mem_byte_off_i, mem_load_data_i)
                          : mem_write_reg_data_i;
      return e;
   endfunction

   task automatic compare_all();
      ent_t e;
      e = '{en: 1'b0, addr: '0, data: '0};
      if (mq.size() > 0) e = mq[0];
      chk("valid", wb_valid_o, mq.size() > 0);
      chk("en",    wb_write_reg_en_o, e.en);
      chk("addr",  wb_write_reg_addr_o, e.addr);
      chk("data",  wb_write_reg_data_o, e.data);
      chk("ready", mem_ready_o, mq.size() < 2);
      chk("cnt",   wb_stall_cnt_o, m_cnt);
   endtask

   // Advance the model from the inputs currently applied, clock the DUT, then compare.
   task automatic tick();
      bit   acc;
      bit   emi;
      ent_t e;
      acc = mem_valid_i && (mq.size() < 2);
      emi = (mq.size() > 0) && wb_ready_i;
      e   = ref_entry();
      if (rst) begin
         mq.delete();
         m_cnt = 0;
      end else begin
         if (mq.size() > 0 && !wb_ready_i && m_cnt < (1 << CW) - 1) m_cnt++;
         if (flush_i) mq.delete();
         else begin
            if (emi) void'(mq.pop_front());
            if (acc) mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_valid_i          = 1'b1;
      mem_write_reg_en_i   = 1'b1;
      mem_write_reg_addr_i = a;
      mem_write_reg_data_i = d;
      mem_load_i           = 1'b0;
   endtask

   task automatic set_load(input logic [1:0] size, input logic sx, input logic [1:0] off);
      mem_valid_i          = 1'b1;
      mem_write_reg_en_i   = 1'b1;
      mem_write_reg_addr_i = 5'd9;
      mem_write_reg_data_i = 32'h1234_5678;
      mem_load_i           = 1'b1;
      mem_load_size_i      = size;
      mem_load_signed_i    = sx;
      mem_byte_off_i       = off;
      mem_load_data_i      = 32'h80F0_7F81;
   endtask

   logic [1:0]    ld_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
   logic          ld_sx   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0]    ld_off  [5] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
   logic [31:0]   ld_exp  [5] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                                  32'h0000_7F81, 32'h80F0_7F81};
   logic [CW-1:0] cnt_before;

   initial begin
      m_cnt = 0;
      rst = 1'b1; flush_i = 1'b0; mem_valid_i = 1'b0; wb_ready_i = 1'b1;
      mem_write_reg_en_i = 1'b0; mem_write_reg_addr_i = '0; mem_write_reg_data_i = '0;
      mem_load_i = 1'b0; mem_load_size_i = 2'b00; mem_load_signed_i = 1'b0;
      mem_byte_off_i = 2'b00; mem_load_data_i = '0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk("rst_valid", wb_valid_o, 1'b0);
      chk("rst_ready", mem_ready_o, 1'b1);
      chk("rst_cnt", wb_stall_cnt_o, 0);

      // Streaming, writeback always ready
      wb_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_alu(AW'(i), DW'(32'h11 * i));
         tick();
         chk("stream_valid", wb_valid_o, 1'b1);
         chk("stream_data", wb_write_reg_data_o, 32'h11 * i);
      end
      mem_valid_i = 1'b0;
      tick();
      chk("stream_cnt", wb_stall_cnt_o, 0);

      // Back-pressure: A to main, B to skid, C held upstream for three cycles
      wb_ready_i = 1'b0;
      set_alu(5'd5, 32'hA); tick();
      set_alu(5'd6, 32'hB); tick();
      set_alu(5'd7, 32'hC);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_ready", mem_ready_o, 1'b0);
         chk("bp_head", wb_write_reg_data_o, 32'hA);
      end
      chk("bp_cnt", wb_stall_cnt_o, 4);
      wb_ready_i = 1'b1;
      tick(); chk("bp_order_b", wb_write_reg_data_o, 32'hB);
      tick(); chk("bp_order_c", wb_write_reg_data_o, 32'hC);
      mem_valid_i = 1'b0;
      tick(); chk("bp_drained", wb_valid_o, 1'b0);

      // Load extraction
      for (int i = 0; i < 5; i++) begin
         set_load(ld_size[i], ld_sx[i], ld_off[i]);
         tick();
         chk("load_ext", wb_write_reg_data_o, ld_exp[i]);
      end
      mem_valid_i = 1'b0;
      tick();

      // Zero-register guard
      set_alu(5'd0, 32'hDEAD); tick();
      chk("x0_en", wb_write_reg_en_o, 1'b0);
      chk("x0_valid", wb_valid_o, 1'b1);
      chk("x0_data", wb_write_reg_data_o, 32'hDEAD);
      mem_valid_i = 1'b0;
      tick();

      // Flush while FULL with a new entry offered in the same cycle
      wb_ready_i = 1'b0;
      set_alu(5'd10, 32'h100); tick();
      set_alu(5'd11, 32'h200); tick();
      chk("fl_full", mem_ready_o, 1'b0);
      cnt_before = wb_stall_cnt_o;
      set_alu(5'd12, 32'h300);
      flush_i = 1'b1; wb_ready_i = 1'b1;
      tick();
      flush_i = 1'b0; mem_valid_i = 1'b0;
      chk("fl_valid", wb_valid_o, 1'b0);
      chk("fl_data", wb_write_reg_data_o, 0);
      chk("fl_ready", mem_ready_o, 1'b1);
      chk("fl_cnt", wb_stall_cnt_o, cnt_before);
      tick();
      chk("fl_dropped", wb_valid_o, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         mem_valid_i          = 1'($urandom_range(0, 2) != 0);
         wb_ready_i           = 1'($urandom_range(0, 2) != 0);
         flush_i              = ($urandom_range(0, 24) == 0);
         mem_write_reg_en_i   = 1'($urandom);
         mem_write_reg_addr_i = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom);
         mem_write_reg_data_i = $urandom;
         mem_load_i           = 1'($urandom);
         mem_load_size_i      = 2'($urandom);
         mem_load_signed_i    = 1'($urandom);
         mem_byte_off_i       = 2'($urandom);
         mem_load_data_i      = $urandom;
         tick();
      end
      flush_i = 1'b0; mem_valid_i = 1'b0;

      // Saturation, then reset in the middle of a stall
      rst = 1'b1; tick(); rst = 1'b0;
      wb_ready_i = 1'b0;
      set_alu(5'd3, 32'h33); tick();
      mem_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt", wb_stall_cnt_o, 15);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_valid", wb_valid_o, 1'b0);
      chk("rst2_data", wb_write_reg_data_o, 0);
      chk("rst2_addr", wb_write_reg_addr_o, 0);
      chk("rst2_cnt", wb_stall_cnt_o, 0);
      chk("rst2_ready", mem_ready_o, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
